c_requantizer: RTL and testbench

// - Post-GEMM stage downstream of the TPU: walks the 128-bit C buffer (4 x int32 accumulators per word),

---
 rtl/c_requantizer_pkg.sv | 30 +++
 rtl/c_requantizer_if.sv | 33 +++
 rtl/c_requantizer_requant_lane.sv | 102 ++++++++++
 rtl/c_requantizer.sv | 145 ++++++++++++++
 tb/tb_c_requantizer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/c_requantizer_pkg.sv
// Shared widths, constants, FSM encoding and latched job configuration for the requantizer.
package c_requantizer_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned IDX_W   = 16;
    localparam int unsigned SHIFT_W = 6;
    localparam int unsigned OFFS_W  = 9;
    localparam int unsigned C_W     = LANES * ACC_W;
    localparam int unsigned O_W     = LANES * OUT_W;

    localparam logic signed [ACC_W-1:0] INT32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] INT32_MIN = 32'sh8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic signed [ACC_W-1:0]   mult;
        logic signed [SHIFT_W-1:0] shift;
        logic signed [OFFS_W-1:0]  offset;
        logic signed [OUT_W-1:0]   act_min;
        logic signed [OUT_W-1:0]   act_max;
    } cfg_t;

endpackage

// File: rtl/c_requantizer_if.sv
// Start/config handshake plus C-buffer read port and output-buffer write port.
interface c_requantizer_if;
    import c_requantizer_pkg::*;

    logic                      in_valid;
    logic [IDX_W-1:0]          word_count;
    logic signed [ACC_W-1:0]   out_multiplier;
    logic signed [SHIFT_W-1:0] out_shift;
    logic signed [OFFS_W-1:0]  output_offset;
    logic signed [OUT_W-1:0]   act_min;
    logic signed [OUT_W-1:0]   act_max;
    logic                      busy;
    logic                      C_wr_en;
    logic [IDX_W-1:0]          C_index;
    logic [C_W-1:0]            C_data_in;
    logic [C_W-1:0]            C_data_out;
    logic                      O_wr_en;
    logic [IDX_W-1:0]          O_index;
    logic [O_W-1:0]            O_data_in;

    modport master (
        output in_valid, word_count, out_multiplier, out_shift, output_offset,
               act_min, act_max, C_data_out,
        input  busy, C_wr_en, C_index, C_data_in, O_wr_en, O_index, O_data_in
    );

    modport slave (
        input  in_valid, word_count, out_multiplier, out_shift, output_offset,
               act_min, act_max, C_data_out,
        output busy, C_wr_en, C_index, C_data_in, O_wr_en, O_index, O_data_in
    );

endinterface

// File: rtl/c_requantizer_requant_lane.sv
// One int32 lane: pre-shift + product (S2), rounding high-mul + rounding right shift (S3),
// offset + clamp (S4). Free-running pipeline; the top tracks validity.
module requant_lane
    import c_requantizer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ACC_W-1:0] acc_i,
    input  cfg_t                    cfg_i,
    output logic        [OUT_W-1:0] q_o
);

    localparam int unsigned P_W   = 2 * ACC_W;
    localparam int unsigned Z_W   = ACC_W + 2;
    localparam int unsigned RSH_W = SHIFT_W - 1;

    localparam logic signed [P_W-1:0] SAT_HI     = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [P_W-1:0] SAT_LO     = 64'shFFFF_FFFF_8000_0000;
    localparam logic signed [P_W-1:0] NUDGE_POS  = 64'sh0000_0000_4000_0000;
    localparam logic signed [P_W-1:0] NUDGE_NEG  = 64'shFFFF_FFFF_C000_0001;
    localparam logic signed [P_W-1:0] TRUNC_BIAS = 64'sh0000_0000_7FFF_FFFF;

    logic signed [P_W-1:0]   acc_ext_c, shl_c, x_ext_c, m_ext_c, sum_c;
    logic signed [ACC_W-1:0] x_c, h_c, hs_c;
    logic        [RSH_W-1:0] rsh_c;
    logic        [ACC_W-1:0] mask_c, rem_c, thr_c;
    logic signed [Z_W-1:0]   z_c, lo_c, hi_c;

    logic signed [P_W-1:0]   prod_d, prod_q;
    logic                    sat_d, sat_q;
    logic signed [ACC_W-1:0] y_d, y_q;
    logic signed [OUT_W-1:0] q_d, q_q;

    // S2: saturating pre-left-shift then full 64-bit signed product
    always_comb begin
        acc_ext_c = {{ACC_W{acc_i[ACC_W-1]}}, acc_i};
        shl_c     = acc_ext_c;
        x_c       = acc_i;
        if (!cfg_i.shift[SHIFT_W-1] && (cfg_i.shift != '0)) begin
            shl_c = acc_ext_c <<< cfg_i.shift[RSH_W-1:0];
            if (shl_c > SAT_HI) begin
                x_c = INT32_MAX;
            end else if (shl_c < SAT_LO) begin
                x_c = INT32_MIN;
            end else begin
                x_c = shl_c[ACC_W-1:0];
            end
        end
        x_ext_c = {{ACC_W{x_c[ACC_W-1]}}, x_c};
        m_ext_c = {{ACC_W{cfg_i.mult[ACC_W-1]}}, cfg_i.mult};
        prod_d  = x_ext_c * m_ext_c;
        sat_d   = (x_c == INT32_MIN) && (cfg_i.mult == INT32_MIN);
    end

    // S3: nudge, divide by 2^31 toward zero, then round-half-away right shift
    always_comb begin
        sum_c = prod_q + (prod_q[P_W-1] ? NUDGE_NEG : NUDGE_POS);
        if (sum_c[P_W-1]) begin
            sum_c = sum_c + TRUNC_BIAS;
        end
        h_c    = sat_q ? INT32_MAX : ACC_W'(sum_c >>> (ACC_W - 1));
        rsh_c  = cfg_i.shift[SHIFT_W-1] ? RSH_W'(-cfg_i.shift) : '0;
        mask_c = (ACC_W'(1) << rsh_c) - ACC_W'(1);
        rem_c  = h_c & mask_c;
        thr_c  = (mask_c >> 1) + ACC_W'(h_c[ACC_W-1]);
        hs_c   = h_c >>> rsh_c;
        y_d    = hs_c + ACC_W'(rem_c > thr_c);
    end

    // S4: add output offset at 34 bits, clamp to activation range
    always_comb begin
        z_c  = {{(Z_W-ACC_W){y_q[ACC_W-1]}}, y_q}
             + {{(Z_W-OFFS_W){cfg_i.offset[OFFS_W-1]}}, cfg_i.offset};
        lo_c = {{(Z_W-OUT_W){cfg_i.act_min[OUT_W-1]}}, cfg_i.act_min};
        hi_c = {{(Z_W-OUT_W){cfg_i.act_max[OUT_W-1]}}, cfg_i.act_max};
        if (z_c < lo_c) begin
            q_d = cfg_i.act_min;
        end else if (z_c > hi_c) begin
            q_d = cfg_i.act_max;
        end else begin
            q_d = z_c[OUT_W-1:0];
        end
    end

    // Pipeline registers S2..S4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            sat_q  <= 1'b0;
            y_q    <= '0;
            q_q    <= '0;
        end else begin
            prod_q <= prod_d;
            sat_q  <= sat_d;
            y_q    <= y_d;
            q_q    <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/c_requantizer.sv
// Streams C words through LANES requant lanes and writes packed int8 words to the output buffer.
module c_requantizer
    import c_requantizer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    c_requantizer_if.slave bus
);

    state_e           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0] o_index_q, o_index_d;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic             o_wr_en_q, o_wr_en_d;
    logic             busy_q, busy_d;
    logic             start_c, last_rd_c, pipe_empty_c;

    logic [OUT_W-1:0] lane_q [LANES];
    logic [O_W-1:0]   lane_pack;

    assign start_c      = bus.in_valid && (state_q == ST_IDLE);
    assign last_rd_c    = (rd_cnt_q == (cnt_q - IDX_W'(1)));
    assign pipe_empty_c = !(v1_q || v2_q || v3_q || o_wr_en_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an empty job goes straight to DRAIN so busy lasts one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = (bus.word_count == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_rd_c) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs/datapath next values: config latch, read/write counters, valid chain
    always_comb begin
        cfg_d     = cfg_q;
        cnt_d     = cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        o_index_d = o_index_q;
        v1_d      = (state_q == ST_RUN);
        v2_d      = v1_q;
        v3_d      = v2_q;
        o_wr_en_d = v3_q;
        busy_d    = (state_d != ST_IDLE);
        if (start_c) begin
            cfg_d.mult    = bus.out_multiplier;
            cfg_d.shift   = bus.out_shift;
            cfg_d.offset  = bus.output_offset;
            cfg_d.act_min = bus.act_min;
            cfg_d.act_max = bus.act_max;
            cnt_d         = bus.word_count;
            rd_cnt_d      = '0;
            wr_cnt_d      = '0;
        end
        if ((state_q == ST_RUN) && !last_rd_c) begin
            rd_cnt_d = rd_cnt_q + IDX_W'(1);
        end
        if (v3_q) begin
            o_index_d = wr_cnt_q;
            wr_cnt_d  = wr_cnt_q + IDX_W'(1);
        end
    end

    // Registered control and output state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            o_index_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            o_wr_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            o_index_q <= o_index_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            o_wr_en_q <= o_wr_en_d;
            busy_q    <= busy_d;
        end
    end

    // Lane 0 occupies the top bits of both the C word and the output word
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        requant_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .acc_i (bus.C_data_out[C_W-1-l*ACC_W -: ACC_W]),
            .cfg_i (cfg_q),
            .q_o   (lane_q[l])
        );
    end

    // Pack lane bytes into the output word
    always_comb begin
        lane_pack = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_pack[O_W-1-l*OUT_W -: OUT_W] = lane_q[l];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.C_wr_en   = 1'b0;
    assign bus.C_index   = rd_cnt_q;
    assign bus.C_data_in = '0;
    assign bus.O_wr_en   = o_wr_en_q;
    assign bus.O_index   = o_index_q;
    assign bus.O_data_in = lane_pack;

endmodule

// File: tb/tb_c_requantizer.sv
// Scoreboard bench for c_requantizer: expected words are queued at job start and popped on each write.
module tb_c_requantizer;
    import c_requantizer_pkg::*;

    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    c_requantizer_if bus_if();

    c_requantizer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t           sb[$];
    logic [C_W-1:0] cmem [64];
    int             n_checks  = 0;
    int             n_errors  = 0;
    int             n_writes  = 0;
    logic [31:0]    last_data = '0;
    int             c_mult, c_shift, c_off, c_min, c_max;

    // Synchronous C buffer, one-cycle read latency
    always @(posedge clk) bus_if.C_data_out <= cmem[bus_if.C_index[5:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_lane(input longint acc);
        longint x, p, nudge, h, mask, rem, thr, y, z;
        int r;
        x = acc;
        if (c_shift > 0) begin
            x = x * (longint'(1) << c_shift);
            if (x > 64'sd2147483647) x = 64'sd2147483647;
            if (x < -64'sd2147483648) x = -64'sd2147483648;
        end
        if (x == -64'sd2147483648 && longint'(c_mult) == -64'sd2147483648) begin
            h = 64'sd2147483647;
        end else begin
            p     = x * longint'(c_mult);
            nudge = (p >= 0) ? 64'sd1073741824 : 64'sd1 - 64'sd1073741824;
            h     = (p + nudge) / 64'sd2147483648;
        end
        r    = (c_shift < 0) ? -c_shift : 0;
        mask = (longint'(1) << r) - 1;
        rem  = h & mask;
        thr  = (mask >>> 1) + ((h < 0) ? 1 : 0);
        y    = (h >>> r) + ((rem > thr) ? 1 : 0);
        z    = y + c_off;
        if (z < c_min) z = c_min;
        if (z > c_max) z = c_max;
        return 8'(z);
    endfunction

    function automatic logic [31:0] model_word(input logic [C_W-1:0] w);
        logic [31:0] r;
        logic [31:0] a;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            a = w[127 - 32*l -: 32];
            r[31 - 8*l -: 8] = model_lane(longint'($signed(a)));
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_acc();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'(int'($urandom_range(0, 2000)) - 1000);
            2:       return ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: return 32'(int'($urandom_range(0, 2000000)) - 1000000);
        endcase
    endfunction

    task automatic set_cfg(input int mult, input int shift, input int off, input int mn, input int mx);
        c_mult  = mult;
        c_shift = shift;
        c_off   = off;
        c_min   = mn;
        c_max   = mx;
    endtask

    // Output monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus_if.O_wr_en) begin
            n_writes++;
            last_data = bus_if.O_data_in;
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("o_index", 64'(bus_if.O_index), 64'(e.idx));
                chk("o_data", 64'(bus_if.O_data_in), 64'(e.data));
            end
        end
    end

    // Queue expectations, then pulse in_valid for one cycle
    task automatic start_job(input int n);
        for (int i = 0; i < n; i++) sb.push_back('{idx: i, data: model_word(cmem[i])});
        @(negedge clk);
        bus_if.in_valid       = 1'b1;
        bus_if.word_count     = 16'(n);
        bus_if.out_multiplier = 32'(c_mult);
        bus_if.out_shift      = 6'(c_shift);
        bus_if.output_offset  = 9'(c_off);
        bus_if.act_min        = 8'(c_min);
        bus_if.act_max        = 8'(c_max);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    // Runs a job to completion; restart_k >= 0 fires a competing start at that busy cycle
    task automatic run_job(input int n, input int restart_k, output int busy_cyc, output int lat);
        int k;
        start_job(n);
        busy_cyc = 0;
        lat      = -1;
        k        = 0;
        while (bus_if.busy && k < 2000) begin
            if (bus_if.O_wr_en && lat < 0) lat = k;
            if (k == restart_k) begin
                bus_if.in_valid       = 1'b1;
                bus_if.word_count     = 16'd3;
                bus_if.out_multiplier = 32'h7FFF_FFFF;
                bus_if.out_shift      = 6'd0;
                bus_if.act_min        = -8'sd5;
                bus_if.act_max        = 8'sd5;
            end else begin
                bus_if.in_valid = 1'b0;
            end
            busy_cyc++;
            k++;
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        chk("busy_bounded", 64'(k < 2000), 64'd1);
    endtask

    initial begin
        int bc, lat, w0, k;
        rst_n                 = 1'b0;
        bus_if.in_valid       = 1'b0;
        bus_if.word_count     = '0;
        bus_if.out_multiplier = '0;
        bus_if.out_shift      = '0;
        bus_if.output_offset  = '0;
        bus_if.act_min        = '0;
        bus_if.act_max        = '0;
        for (int i = 0; i < 64; i++) cmem[i] = '0;
        set_cfg(0, 0, 0, -128, 127);
        repeat (3) @(negedge clk);

        chk("rst_busy",    64'(bus_if.busy),      64'd0);
        chk("rst_o_wr_en", 64'(bus_if.O_wr_en),   64'd0);
        chk("rst_c_index", 64'(bus_if.C_index),   64'd0);
        chk("rst_o_index", 64'(bus_if.O_index),   64'd0);
        chk("rst_o_data",  64'(bus_if.O_data_in), 64'd0);
        chk("c_wr_en",     64'(bus_if.C_wr_en),   64'd0);
        chk("c_data_in",   64'(bus_if.C_data_in != '0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic single word, known packed result
        cmem[0] = {32'sd101, 32'sd0, -32'sd1, 32'sd200};
        set_cfg(32'h4000_0000, -1, -128, -128, 127);
        w0 = n_writes;
        run_job(1, -1, bc, lat);
        chk("basic_busy",   64'(bc), 64'd6);
        chk("basic_lat",    64'(lat), 64'd4);
        chk("basic_writes", 64'(n_writes - w0), 64'd1);
        chk("basic_word",   64'(last_data), 64'h9A80_80B2);

        // Clamp to a narrow activation range
        cmem[0] = {32'sd100000, -32'sd100000, 32'sd0, 32'sd5};
        set_cfg(32'h7FFF_FFFF, 0, 0, -10, 10);
        run_job(1, -1, bc, lat);
        chk("clamp_word", 64'(last_data), 64'h0AF6_0005);

        // Maximum left shift saturates the pre-shift
        cmem[0] = {32'sd2, -32'sd2, 32'sd0, 32'sd1};
        set_cfg(32'h4000_0000, 31, 0, -128, 127);
        run_job(1, -1, bc, lat);
        chk("sat_word", 64'(last_data), 64'h7F80_007F);

        // Empty job
        w0 = n_writes;
        run_job(0, -1, bc, lat);
        chk("zero_busy",   64'(bc), 64'd1);
        chk("zero_writes", 64'(n_writes - w0), 64'd0);

        // 64-word random stream
        for (int i = 0; i < 64; i++) cmem[i] = {rand_acc(), rand_acc(), rand_acc(), rand_acc()};
        set_cfg(int'(32'h4000_0000 | ($urandom & 32'h3FFF_FFFF)),
                int'($urandom_range(0, 16)) - 12, int'($urandom_range(0, 255)) - 128, -100, 90);
        w0 = n_writes;
        run_job(64, -1, bc, lat);
        chk("stream_busy",   64'(bc), 64'd69);
        chk("stream_writes", 64'(n_writes - w0), 64'd64);
        chk("stream_sb",     64'(sb.size()), 64'd0);

        // Competing start while busy must be ignored
        for (int i = 0; i < 8; i++) cmem[i] = {rand_acc(), rand_acc(), rand_acc(), rand_acc()};
        set_cfg(int'(32'h4000_0000 | ($urandom & 32'h3FFF_FFFF)), -3, 7, -128, 127);
        w0 = n_writes;
        run_job(8, 2, bc, lat);
        chk("restart_busy",   64'(bc), 64'd13);
        chk("restart_writes", 64'(n_writes - w0), 64'd8);
        chk("restart_sb",     64'(sb.size()), 64'd0);

        // Reset during the third write of a 16-word job
        for (int i = 0; i < 16; i++) cmem[i] = {rand_acc(), rand_acc(), rand_acc(), rand_acc()};
        set_cfg(int'(32'h4000_0000 | ($urandom & 32'h3FFF_FFFF)), -5, 0, -128, 127);
        w0 = n_writes;
        start_job(16);
        k = 0;
        while ((n_writes - w0) < 3 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rst_reach3", 64'(n_writes - w0), 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_o_wr_en", 64'(bus_if.O_wr_en), 64'd0);
        chk("midrst_busy",    64'(bus_if.busy),    64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w0 = n_writes;
        repeat (20) @(negedge clk);
        chk("midrst_no_writes", 64'(n_writes - w0), 64'd0);
        chk("midrst_idle",      64'(bus_if.busy),   64'd0);

        // Recovery after reset
        cmem[0] = {32'sd101, 32'sd0, -32'sd1, 32'sd200};
        set_cfg(32'h4000_0000, -1, -128, -128, 127);
        run_job(1, -1, bc, lat);
        chk("recover_busy", 64'(bc), 64'd6);
        chk("recover_word", 64'(last_data), 64'h9A80_80B2);
        chk("final_sb",     64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
